// File: rtl/lift_req_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : lift_req_queue_if
// Description : Hall-call queue bus. Buttons and the FSM "done" strobe come
//               in. Head code, empty flag, lamps and occupancy go out.
// Revision    : 1.0  initial release
// ============================================================================
interface lift_req_queue_if #(
    parameter int ADDR_W = 3
);
    logic [5:0]      btn;
    logic            done;
    logic [2:0]      din;
    logic            q_empty;
    logic [5:0]      lamp;
    logic [ADDR_W:0] q_count;

    // Environment side: drives the buttons and the FSM handshake
    modport master (
        output btn,
        output done,
        input  din,
        input  q_empty,
        input  lamp,
        input  q_count
    );

    // Queue side
    modport slave (
        input  btn,
        input  done,
        output din,
        output q_empty,
        output lamp,
        output q_count
    );
endinterface
`default_nettype wire

// File: rtl/lift_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : lift_req_queue
// Description : Hall-call request queue ahead of the lift FSM. Edge-detects
//               the six hall buttons and latches each new call. Calls are
//               de-duplicated against anything already latched or queued.
//               One latched call per cycle moves into a FIFO, lowest button
//               index first. The head code is presented to the FSM and is
//               popped on "done".
// Revision    : 1.0  initial release
// ============================================================================
module lift_req_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    lift_req_queue_if.slave   bus
);

    localparam logic [ADDR_W:0] C_FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_COUNT_ONE  = (ADDR_W+1)'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [5:0]        r_btn_prev;   // previous button levels, for edge detect
    logic [5:0]        r_latch;      // calls seen but not yet in the FIFO
    logic [5:0]        r_inq;        // calls currently held in the FIFO
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic [2:0]        r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [5:0] w_press;
    logic       w_empty;
    logic       w_full;
    logic [2:0] w_head;
    logic       w_pop;
    logic [5:0] w_pop_oh;
    logic       w_push;
    logic [2:0] w_sel_idx;
    logic [5:0] w_push_oh;
    logic [2:0] w_push_code;
    logic [5:0] w_accept;
    logic [5:0] w_latch_nxt;
    logic [5:0] w_inq_nxt;

    assign w_press = bus.btn & ~r_btn_prev;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL_COUNT);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_pop   = bus.done & ~w_empty;

    // Map the head call code back to its button bit so its lamp can be released
    always_comb begin
        w_pop_oh = 6'b000000;
        if (w_pop) begin
            case (w_head)
                3'b001:  w_pop_oh = 6'b000001;
                3'b010:  w_pop_oh = 6'b000010;
                3'b011:  w_pop_oh = 6'b000100;
                3'b110:  w_pop_oh = 6'b001000;
                3'b111:  w_pop_oh = 6'b010000;
                3'b100:  w_pop_oh = 6'b100000;
                default: w_pop_oh = 6'b000000;
            endcase
        end
    end

    // Priority-select the lowest-index latched call as the push candidate
    always_comb begin
        w_sel_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (r_latch[i]) begin
                w_sel_idx = 3'(i);
            end
        end
    end

    // A pop frees a slot at the same edge, so a full FIFO can still accept
    assign w_push    = (|r_latch) & (~w_full | w_pop);
    assign w_push_oh = w_push ? (6'b000001 << w_sel_idx) : 6'b000000;

    // Encode the selected button index into its call code
    always_comb begin
        w_push_code = 3'b000;
        case (w_sel_idx)
            3'd0:    w_push_code = 3'b001;
            3'd1:    w_push_code = 3'b010;
            3'd2:    w_push_code = 3'b011;
            3'd3:    w_push_code = 3'b110;
            3'd4:    w_push_code = 3'b111;
            3'd5:    w_push_code = 3'b100;
            default: w_push_code = 3'b000;
        endcase
    end

    // A new press is taken only when that call is neither latched nor queued.
    // A queued call that leaves the FIFO on this very edge counts as free.
    assign w_accept = w_press & ~r_latch & (~r_inq | w_pop_oh);

    // latch and inq are mutually exclusive per bit, so a push never
    // collides with a pop or an accept on the same call.
    assign w_latch_nxt = (r_latch & ~w_push_oh) | w_accept;
    assign w_inq_nxt   = (r_inq & ~w_pop_oh) | w_push_oh;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Button history and per-call bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 6'b000000;
            r_latch    <= 6'b000000;
            r_inq      <= 6'b000000;
        end else begin
            r_btn_prev <= bus.btn;
            r_latch    <= w_latch_nxt;
            r_inq      <= w_inq_nxt;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_COUNT_ONE;
                2'b01:   r_count <= r_count - C_COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage. No reset is needed: contents are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_code;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.din     = w_empty ? 3'b000 : w_head;
    assign bus.q_empty = w_empty;
    assign bus.lamp    = r_latch | r_inq;
    assign bus.q_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lift_req_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_lift_req_queue
// Description : Directed, table-driven bench for lift_req_queue.
//               Instance A uses DEPTH=8 and instance B uses DEPTH=4, which
//               covers the FIFO-full case.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lift_req_queue;

    logic clk;
    logic rst_n;

    lift_req_queue_if #(.ADDR_W(3)) bus_a ();
    lift_req_queue_if #(.ADDR_W(2)) bus_b ();

    lift_req_queue #(.DEPTH(8), .ADDR_W(3)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    lift_req_queue #(.DEPTH(4), .ADDR_W(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sel;     // 0 = instance A, 1 = instance B
        logic [5:0] btn;
        logic       done;
        logic [2:0] din;
        logic       empty;
        logic [5:0] lamp;
        logic [3:0] count;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic sel, input logic [5:0] btn, input logic done,
                                input logic [2:0] din, input logic empty,
                                input logic [5:0] lamp, input logic [3:0] count);
        vec_t v;
        v.sel   = sel;
        v.btn   = btn;
        v.done  = done;
        v.din   = din;
        v.empty = empty;
        v.lamp  = lamp;
        v.count = count;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [2:0] din, input logic empty,
                           input logic [5:0] lamp, input logic [3:0] count);
        check({tag, " din"},     {5'b0, bus_a.din},     {5'b0, din});
        check({tag, " q_empty"}, {7'b0, bus_a.q_empty}, {7'b0, empty});
        check({tag, " lamp"},    {2'b0, bus_a.lamp},    {2'b0, lamp});
        check({tag, " q_count"}, {4'b0, bus_a.q_count}, {4'b0, count});
    endtask

    task automatic check_b(input string tag, input logic [2:0] din, input logic empty,
                           input logic [5:0] lamp, input logic [3:0] count);
        check({tag, " din"},     {5'b0, bus_b.din},     {5'b0, din});
        check({tag, " q_empty"}, {7'b0, bus_b.q_empty}, {7'b0, empty});
        check({tag, " lamp"},    {2'b0, bus_b.lamp},    {2'b0, lamp});
        check({tag, " q_count"}, {5'b0, bus_b.q_count}, {4'b0, count});
    endtask

    // Watchdog so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- Vector table ----------------
        // Single call: latched at edge k, queued at k+1, popped by done
        tbl.push_back(mk(1'b0, 6'b000100, 1'b0, 3'b000, 1'b1, 6'b000100, 4'd0));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b0, 3'b011, 1'b0, 6'b000100, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b1, 3'b000, 1'b1, 6'b000000, 4'd0));
        // Two simultaneous calls with done held: 001 leaves first, then 100
        tbl.push_back(mk(1'b0, 6'b100001, 1'b1, 3'b000, 1'b1, 6'b100001, 4'd0));
        tbl.push_back(mk(1'b0, 6'b100001, 1'b1, 3'b001, 1'b0, 6'b100001, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b1, 3'b100, 1'b0, 6'b100000, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b1, 3'b000, 1'b1, 6'b000000, 4'd0));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b0, 3'b000, 1'b1, 6'b000000, 4'd0));
        // Duplicate presses of 2U while queued are ignored
        tbl.push_back(mk(1'b0, 6'b000010, 1'b0, 3'b000, 1'b1, 6'b000010, 4'd0));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b0, 3'b010, 1'b0, 6'b000010, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000010, 1'b0, 3'b010, 1'b0, 6'b000010, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b0, 3'b010, 1'b0, 6'b000010, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000010, 1'b0, 3'b010, 1'b0, 6'b000010, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b0, 3'b010, 1'b0, 6'b000010, 4'd1));
        // Press on the pop edge is accepted and re-queued next edge
        tbl.push_back(mk(1'b0, 6'b000010, 1'b1, 3'b000, 1'b1, 6'b000010, 4'd0));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b0, 3'b010, 1'b0, 6'b000010, 4'd1));
        tbl.push_back(mk(1'b0, 6'b000000, 1'b1, 3'b000, 1'b1, 6'b000000, 4'd0));
        // DEPTH=4: all six pressed. Four calls queue in index order and
        // 3D (111) and 4D (100) stay latched with their lamps lit.
        tbl.push_back(mk(1'b1, 6'b111111, 1'b0, 3'b000, 1'b1, 6'b111111, 4'd0));
        tbl.push_back(mk(1'b1, 6'b111111, 1'b0, 3'b001, 1'b0, 6'b111111, 4'd1));
        tbl.push_back(mk(1'b1, 6'b111111, 1'b0, 3'b001, 1'b0, 6'b111111, 4'd2));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b0, 3'b001, 1'b0, 6'b111111, 4'd3));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b0, 3'b001, 1'b0, 6'b111111, 4'd4));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b0, 3'b001, 1'b0, 6'b111111, 4'd4));
        // Pop while full: 111 is pushed at the same edge and the count holds at 4
        tbl.push_back(mk(1'b1, 6'b000000, 1'b1, 3'b010, 1'b0, 6'b111110, 4'd4));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b1, 3'b011, 1'b0, 6'b111100, 4'd4));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b1, 3'b110, 1'b0, 6'b111000, 4'd3));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b1, 3'b111, 1'b0, 6'b110000, 4'd2));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b1, 3'b100, 1'b0, 6'b100000, 4'd1));
        tbl.push_back(mk(1'b1, 6'b000000, 1'b1, 3'b000, 1'b1, 6'b000000, 4'd0));

        // ---------------- Reset state ----------------
        rst_n      = 1'b0;
        bus_a.btn  = 6'b0;
        bus_a.done = 1'b0;
        bus_b.btn  = 6'b0;
        bus_b.done = 1'b0;
        #12;
        check_a("reset A", 3'b000, 1'b1, 6'b000000, 4'd0);
        check_b("reset B", 3'b000, 1'b1, 6'b000000, 4'd0);
        rst_n = 1'b1;
        step();

        // ---------------- Table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].sel) begin
                bus_b.btn  = tbl[i].btn;
                bus_b.done = tbl[i].done;
                bus_a.btn  = 6'b0;
                bus_a.done = 1'b0;
            end else begin
                bus_a.btn  = tbl[i].btn;
                bus_a.done = tbl[i].done;
                bus_b.btn  = 6'b0;
                bus_b.done = 1'b0;
            end
            step();
            if (tbl[i].sel)
                check_b($sformatf("v%0d", i), tbl[i].din, tbl[i].empty, tbl[i].lamp, tbl[i].count);
            else
                check_a($sformatf("v%0d", i), tbl[i].din, tbl[i].empty, tbl[i].lamp, tbl[i].count);
        end
        bus_b.btn  = 6'b0;
        bus_b.done = 1'b0;

        // ---------------- Asynchronous reset mid-operation ----------------
        bus_a.btn = 6'b000111;
        step();
        bus_a.btn = 6'b000000;
        step();
        step();
        step();
        check_a("pre-reset", 3'b001, 1'b0, 6'b000111, 4'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check_a("async reset", 3'b000, 1'b1, 6'b000000, 4'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_a($sformatf("post-reset%0d", k), 3'b000, 1'b1, 6'b000000, 4'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
